// File: rtl/rca_pkg.sv
// ----------------------------------------------------------------------------
// rca_pkg
// Shared definitions for the pipelined ripple-carry adder/subtractor:
// default widths, the stage-count helper and the default-width stage layout.
// No ports (package).
// ----------------------------------------------------------------------------
package rca_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SEG   = 8;

    // Number of pipeline stages; a zero segment width is rejected by the top,
    // so it maps to 1 here only to keep the division defined.
    function automatic int unsigned calc_nstg(input int unsigned width,
                                              input int unsigned seg);
        return (seg == 0) ? 32'd1 : width / seg;
    endfunction

    // Stage register layout at the default width. The top re-declares the
    // same layout at its own WIDTH so the fields track the parameters.
    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] sum_lo;
        logic                 carry;
        logic [DEF_WIDTH-1:0] a_hi;
        logic [DEF_WIDTH-1:0] b_hi;
        logic                 a_msb;
        logic                 b_msb;
    } rca_stage_t;

endpackage

// File: rtl/rca_segment.sv
// ----------------------------------------------------------------------------
// rca_segment
// Purely combinational SEG-bit ripple-carry slice made of full adders.
// Ports:
//   a, b : SEG-bit operands
//   ci   : carry in
//   s    : SEG-bit sum
//   co   : carry out of the top bit
// ----------------------------------------------------------------------------
module rca_segment
    import rca_pkg::*;
#(
    parameter int unsigned SEG = DEF_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    // One full adder per bit; each links to the previous bit's carry.
    for (genvar k = 0; k < SEG; k++) begin : g_fa
        logic w_cin;
        logic w_cout;

        if (k == 0) begin : g_first
            assign w_cin = ci;
        end else begin : g_rest
            assign w_cin = g_fa[k-1].w_cout;
        end

        assign s[k]   = a[k] ^ b[k] ^ w_cin;
        assign w_cout = (a[k] & b[k]) | (w_cin & (a[k] ^ b[k]));
    end

    assign co = g_fa[SEG-1].w_cout;

endmodule

// File: rtl/rca_pipe_adder.sv
// ----------------------------------------------------------------------------
// rca_pipe_adder
// Pipelined WIDTH-bit ripple-carry adder/subtractor. The carry chain is cut
// into SEG-bit segments with one register stage each (latency NSTG), with a
// valid/ready handshake and full backpressure.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand beat handshake (in_ready is combinational)
//   a, b, c, sub        : operands, carry-in (add only), 1 = a - b
//   out_valid/out_ready : result handshake
//   foo, cout, ovf      : sum/difference, MSB carry-out, signed overflow
// ----------------------------------------------------------------------------
module rca_pipe_adder
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] foo,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTG = calc_nstg(WIDTH, SEG);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] sum_lo;
        logic             carry;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
        logic             a_msb;
        logic             b_msb;
    } stage_t;

    // Reject geometries that cannot be cut into whole segments.
    if (SEG < 1) begin : g_bad_seg
        $error("rca_pipe_adder: SEG must be at least 1");
    end else if ((WIDTH % SEG) != 0) begin : g_bad_width
        $error("rca_pipe_adder: WIDTH must be a multiple of SEG");
    end

    stage_t           r_stg [NSTG];
    logic             r_ovf;
    logic [WIDTH-1:0] w_b_eff;

    // Subtraction is a + ~b + 1.
    assign w_b_eff = sub ? ~b : b;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_b_in;
        logic [WIDTH-1:0] w_sum_in;
        logic             w_ci;
        logic             w_amsb;
        logic             w_bmsb;
        logic             w_vin;
        logic             w_load;
        logic [SEG-1:0]   w_s;
        logic             w_co;

        // Stage inputs: prepared operands at the head, previous stage after.
        if (k == 0) begin : g_head
            assign w_a_in   = a;
            assign w_b_in   = w_b_eff;
            assign w_sum_in = '0;
            assign w_ci     = sub | c;
            assign w_amsb   = a[WIDTH-1];
            assign w_bmsb   = w_b_eff[WIDTH-1];
            assign w_vin    = in_valid;
        end else begin : g_body
            assign w_a_in   = r_stg[k-1].a_hi;
            assign w_b_in   = r_stg[k-1].b_hi;
            assign w_sum_in = r_stg[k-1].sum_lo;
            assign w_ci     = r_stg[k-1].carry;
            assign w_amsb   = r_stg[k-1].a_msb;
            assign w_bmsb   = r_stg[k-1].b_msb;
            assign w_vin    = r_stg[k-1].valid;
        end

        // A stage loads when empty or when its successor takes its beat.
        if (k == NSTG - 1) begin : g_tail
            assign w_load = !r_stg[k].valid || out_ready;

            // Overflow is resolved once the MSB segment is summed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_load && w_vin) begin
                    r_ovf <= (w_amsb == w_bmsb) && (w_s[SEG-1] != w_amsb);
                end
            end
        end else begin : g_mid
            assign w_load = !r_stg[k].valid || g_stg[k+1].w_load;
        end

        rca_segment #(
            .SEG (SEG)
        ) u_seg (
            .a  (w_a_in[SEG-1:0]),
            .b  (w_b_in[SEG-1:0]),
            .ci (w_ci),
            .s  (w_s),
            .co (w_co)
        );

        // Operands shift down one segment per stage; the sum fills from the
        // top so that after NSTG stages every segment sits in place.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stg[k] <= '0;
            end else if (w_load) begin
                r_stg[k].valid <= w_vin;
                if (w_vin) begin
                    r_stg[k].sum_lo <= (w_sum_in >> SEG)
                                     | (WIDTH'(w_s) << (WIDTH - SEG));
                    r_stg[k].carry  <= w_co;
                    r_stg[k].a_hi   <= w_a_in >> SEG;
                    r_stg[k].b_hi   <= w_b_in >> SEG;
                    r_stg[k].a_msb  <= w_amsb;
                    r_stg[k].b_msb  <= w_bmsb;
                end
            end
        end
    end

    assign in_ready  = g_stg[0].w_load;
    assign out_valid = r_stg[NSTG-1].valid;
    assign foo       = r_stg[NSTG-1].sum_lo;
    assign cout      = r_stg[NSTG-1].carry;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_rca_pipe_adder.sv
// ----------------------------------------------------------------------------
// tb_rca_pipe_adder
// Self-checking bench for rca_pipe_adder (32/8 instance plus an 8/8 instance).
// ----------------------------------------------------------------------------
module tb_rca_pipe_adder;

    typedef struct packed {
        logic [31:0] foo;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        sub;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, c, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, foo;

    logic        in_valid8, in_ready8, c8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, foo8;

    always #5 clk = ~clk;

    rca_pipe_adder #(.WIDTH(32), .SEG(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .foo(foo), .cout(cout), .ovf(ovf)
    );

    rca_pipe_adder #(.WIDTH(8), .SEG(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .c(c8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(out_ready8), .foo(foo8), .cout(cout8), .ovf(ovf8)
    );

    int   errs = 0;
    int   checks = 0;
    int   n_in = 0;
    int   n_out = 0;
    res_t exp_q[$];
    logic last_acc, last_in_ready;
    logic held = 1'b0;
    res_t held_val;
    logic tbl_mode = 1'b0;
    res_t tbl_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t mk(input logic [31:0] f, input logic co, input logic ov);
        res_t r;
        r.foo  = f;
        r.cout = co;
        r.ovf  = ov;
        return r;
    endfunction

    // Reference: plain unsigned/signed arithmetic on the operands.
    function automatic res_t model(input logic [31:0] ia, input logic [31:0] ib,
                                   input logic ic, input logic isub);
        res_t        r;
        longint      sa, sb, ss;
        logic [32:0] u;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        if (isub) begin
            ss     = sa - sb;
            r.foo  = ia - ib;
            r.cout = (ia >= ib);
        end else begin
            ss     = sa + sb + longint'(ic);
            u      = 33'(ia) + 33'(ib) + 33'(ic);
            r.foo  = u[31:0];
            r.cout = u[32];
        end
        r.ovf = (ss > 64'sh7FFFFFFF) || (ss < -64'sh80000000);
        return r;
    endfunction

    // One cycle: drive at negedge, observe the transfers due at the next posedge.
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ic, input logic isub, input logic ior);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        c         = ic;
        sub       = isub;
        out_ready = ior;
        #1;
        if (held) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", 64'({foo, cout, ovf}), 64'(held_val));
        end
        last_in_ready = in_ready;
        last_acc      = iv && in_ready;
        if (last_acc) begin
            exp_q.push_back(tbl_mode ? tbl_exp : model(ia, ib, ic, isub));
            n_in++;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_output: got foo=0x%0h with no beat outstanding", foo);
            end else begin
                chk("result", 64'({foo, cout, ovf}), 64'(exp_q.pop_front()));
            end
            n_out++;
        end
        held     = out_valid && !out_ready;
        held_val = {foo, cout, ovf};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [8];
        logic [31:0] bt_a [10];
        logic [31:0] bt_b [10];
        logic        bt_c [10];
        logic        bt_s [10];
        int          i, j, s, lat, base_in, base_out, sent, guard;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = 1'b0; sub = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_foo", 64'(foo), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Directed vectors, one beat at a time through an idle pipe
        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, mk(32'h00000000, 1'b1, 1'b0)};
        tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, mk(32'h80000000, 1'b0, 1'b1)};
        tbl[2] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, mk(32'h7FFFFFFF, 1'b1, 1'b1)};
        tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, mk(32'hFFFFFFFE, 1'b0, 1'b0)};
        tbl[4] = '{32'h00000012, 32'h00000034, 1'b1, 1'b0, mk(32'h00000047, 1'b0, 1'b0)};
        tbl[5] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, mk(32'h00000000, 1'b1, 1'b1)};
        tbl[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, mk(32'h00000001, 1'b0, 1'b0)};
        tbl[7] = '{32'h00001234, 32'h00001234, 1'b0, 1'b1, mk(32'h00000000, 1'b1, 1'b0)};
        for (int t = 0; t < 8; t++) begin
            tbl_mode = 1'b1;
            tbl_exp  = tbl[t].exp;
            base_in  = n_in;
            base_out = n_out;
            step(1'b1, tbl[t].a, tbl[t].b, tbl[t].c, tbl[t].sub, 1'b1);
            tbl_mode = 1'b0;
            chk("tbl_accept", 64'(n_in - base_in), 64'd1);
            lat = 0;
            while (n_out == base_out && lat < 20) begin
                step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
                lat++;
            end
            chk("tbl_latency", 64'(lat), 64'd4);
        end

        // Back-to-back beats, consumer stalls from the third cycle
        for (int k = 0; k < 10; k++) begin
            bt_a[k] = $urandom;
            bt_b[k] = $urandom;
            bt_c[k] = 1'($urandom);
            bt_s[k] = 1'($urandom);
        end
        i = 0;
        s = 0;
        while (s < 20) begin
            j = (i < 10) ? i : 9;
            step(1'b1, bt_a[j], bt_b[j], bt_c[j], bt_s[j], s < 2);
            if (last_acc) i++;
            s++;
            if (!last_in_ready) break;
        end
        chk("fill_count", 64'(i), 64'd4);
        repeat (3) begin
            j = (i < 10) ? i : 9;
            step(1'b1, bt_a[j], bt_b[j], bt_c[j], bt_s[j], 1'b0);
            if (last_acc) i++;
            chk("stall_in_ready", 64'(last_in_ready), 64'd0);
        end
        base_out = n_out;
        repeat (10) begin
            j = (i < 10) ? i : 9;
            step(i < 10, bt_a[j], bt_b[j], bt_c[j], bt_s[j], 1'b1);
            if (last_acc) i++;
        end
        chk("no_gap_outputs", 64'(n_out - base_out), 64'd10);
        chk("all_accepted", 64'(i), 64'd10);

        // Random traffic with random backpressure
        sent  = 0;
        guard = 0;
        while (sent < 10000 && guard < 60000) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0);
            if (last_acc) sent++;
            guard++;
        end
        chk("random_sent", 64'(sent), 64'd10000);
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("in_out_balance", 64'(n_out), 64'(n_in));

        // Reset with three beats in flight, oldest already presented
        repeat (3) step(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
        repeat (2) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_foo", 64'(foo), 64'd0);
        chk("async_rst_cout", 64'(cout), 64'd0);
        chk("async_rst_ovf", 64'(ovf), 64'd0);
        exp_q.delete();
        held = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
            chk("no_stale_beat", 64'(out_valid), 64'd0);
        end

        // Single-stage instance: 0xFF + 0x01 + 1
        @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c8 = 1'b1; sub8 = 1'b0;
        #1;
        chk("w8_in_ready", 64'(in_ready8), 64'd1);
        chk("w8_idle", 64'(out_valid8), 64'd0);
        @(negedge clk);
        in_valid8 = 1'b0;
        #1;
        chk("w8_valid", 64'(out_valid8), 64'd1);
        chk("w8_result", 64'({foo8, cout8, ovf8}), 64'({8'h01, 1'b1, 1'b0}));
        @(negedge clk);
        #1;
        chk("w8_consumed", 64'(out_valid8), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
